// File: rtl/pixel_loader_pkg.sv
// Shared widths, channel positions and FSM encoding for the pixel loader.
package pixel_pkg;
  localparam int PIXEL_W = 24;
  localparam int CH_W    = 8;
  localparam int R_LSB   = 16;
  localparam int G_LSB   = 8;
  localparam int B_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    CHECK = 2'b10,
    DONE  = 2'b11
  } state_e;
endpackage

// File: rtl/pixel_loader_if.sv
// Byte-in / pixel-RAM-out bundle; master is the UART/controller side, slave the loader.
interface pixel_loader_if #(parameter int ADDR_BITS = 10);
  import pixel_pkg::*;
  logic                 start;
  logic [CH_W-1:0]      rx_data;
  logic                 rx_valid;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [PIXEL_W-1:0]   mem_di;
  logic                 busy;
  logic                 done;
  logic [ADDR_BITS:0]   pix_count;
  logic                 chk_err;

  modport master (
    output start, rx_data, rx_valid,
    input  mem_we, mem_addr, mem_di, busy, done, pix_count, chk_err
  );
  modport slave (
    input  start, rx_data, rx_valid,
    output mem_we, mem_addr, mem_di, busy, done, pix_count, chk_err
  );
endinterface

// File: rtl/pixel_loader_rgb_packer.sv
// Packs R,G,B bytes into one 24-bit word; word_valid_o pulses the cycle after the B byte.
module rgb_packer
  import pixel_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [CH_W-1:0]    byte_i,
  output logic [PIXEL_W-1:0] word_o,
  output logic               word_valid_o
);
  logic [1:0]         idx_q, idx_d;
  logic [CH_W-1:0]    r_q, r_d, g_q, g_d;
  logic [PIXEL_W-1:0] word_q, word_d;
  logic               vld_q, vld_d;

  always_comb begin
    idx_d  = idx_q;
    r_d    = r_q;
    g_d    = g_q;
    word_d = word_q;
    vld_d  = 1'b0;
    if (clr_i) begin
      idx_d = 2'd0;
    end else if (en_i) begin
      case (idx_q)
        2'd0: begin r_d = byte_i; idx_d = 2'd1; end
        2'd1: begin g_d = byte_i; idx_d = 2'd2; end
        default: begin
          word_d[R_LSB +: CH_W] = r_q;
          word_d[G_LSB +: CH_W] = g_q;
          word_d[B_LSB +: CH_W] = byte_i;
          vld_d = 1'b1;
          idx_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      r_q    <= '0;
      g_q    <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      r_q    <= r_d;
      g_q    <= g_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = vld_q;
endmodule

// File: rtl/pixel_loader.sv
// Loads a UART byte stream as RGB pixels into the source pixel RAM.
// Optional trailing XOR checksum byte under PIXEL_LOADER_CHKSUM_EN.
module pixel_loader
  import pixel_pkg::*;
#(
  parameter int ADDR_BITS  = 10,
  parameter int NUM_PIXELS = 1024
) (
  input  logic           clk,
  input  logic           reset,
  pixel_loader_if.slave  bus
);
  localparam logic [ADDR_BITS:0] LAST_CNT = (ADDR_BITS+1)'(NUM_PIXELS-1);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS:0]   cnt_q, cnt_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 pk_we, accept, last_pix;
  logic [PIXEL_W-1:0]   pk_word;

  assign last_pix = (cnt_q == LAST_CNT);
  // Bytes arriving while the final pixel is being written belong to no pixel.
  assign accept = (state_q == LOAD) && bus.rx_valid && !bus.start && !(pk_we && last_pix);

  rgb_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (bus.start),
    .en_i         (accept),
    .byte_i       (bus.rx_data),
    .word_o       (pk_word),
    .word_valid_o (pk_we)
  );

`ifdef PIXEL_LOADER_CHKSUM_EN
  logic [CH_W-1:0] xor_q, xor_d;
  logic            chk_err_q, chk_err_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
`ifdef PIXEL_LOADER_CHKSUM_EN
    xor_d     = xor_q;
    chk_err_d = chk_err_q;
`endif
    if (bus.start) begin
      state_d = LOAD;
      addr_d  = '0;
      cnt_d   = '0;
`ifdef PIXEL_LOADER_CHKSUM_EN
      xor_d     = '0;
      chk_err_d = 1'b0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
`ifdef PIXEL_LOADER_CHKSUM_EN
          if (accept) xor_d = xor_q ^ bus.rx_data;
`endif
          if (pk_we) begin
            cnt_d = cnt_q + (ADDR_BITS+1)'(1);
            if (last_pix) begin
              addr_d = '0;
`ifdef PIXEL_LOADER_CHKSUM_EN
              state_d = CHECK;
`else
              state_d = DONE;
`endif
            end else begin
              addr_d = addr_q + ADDR_BITS'(1);
            end
          end
        end
`ifdef PIXEL_LOADER_CHKSUM_EN
        CHECK: begin
          if (bus.rx_valid) begin
            chk_err_d = (bus.rx_data != xor_q);
            state_d   = DONE;
          end
        end
`endif
        default: ;
      endcase
    end
    busy_d = (state_d == LOAD) || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef PIXEL_LOADER_CHKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xor_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      xor_q     <= xor_d;
      chk_err_q <= chk_err_d;
    end
  end
  assign bus.chk_err = chk_err_q;
`else
  assign bus.chk_err = 1'b0;
`endif

  assign bus.mem_we    = pk_we;
  assign bus.mem_di    = pk_word;
  assign bus.mem_addr  = addr_q;
  assign bus.pix_count = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_pixel_loader.sv
// Directed bench for pixel_loader: vector table for a 4-pixel frame plus corner sequences.
module tb_pixel_loader;
  localparam int AB = 10;
  localparam int NP = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pixel_loader_if #(.ADDR_BITS(AB)) bus();
  pixel_loader #(.ADDR_BITS(AB), .NUM_PIXELS(NP)) dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef PIXEL_LOADER_CHKSUM_EN
  pixel_loader_if #(.ADDR_BITS(AB)) bus1();
  pixel_loader #(.ADDR_BITS(AB), .NUM_PIXELS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic          start;
    logic          rv;
    logic [7:0]    d;
    logic          we;
    logic [AB-1:0] addr;
    logic [23:0]   di;
    logic [AB:0]   cnt;
    logic          busy;
    logic          done;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic [7:0] d);
    @(negedge clk);
    bus.start = s; bus.rx_valid = v; bus.rx_data = d;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.rx_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic we, input logic [AB-1:0] addr,
                            input logic [23:0] di, input logic [AB:0] cnt,
                            input logic busy, input logic done, input logic ce);
    chk({tag, ".we"}, 32'(bus.mem_we), 32'(we));
    if (we) chk({tag, ".di"}, 32'(bus.mem_di), 32'(di));
    chk({tag, ".addr"}, 32'(bus.mem_addr), 32'(addr));
    chk({tag, ".cnt"}, 32'(bus.pix_count), 32'(cnt));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
    chk({tag, ".done"}, 32'(bus.done), 32'(done));
    chk({tag, ".chk_err"}, 32'(bus.chk_err), 32'(ce));
  endtask

  task automatic set_vec(input int i, input logic s, input logic v, input logic [7:0] d,
                         input logic we, input logic [AB-1:0] addr, input logic [23:0] di,
                         input logic [AB:0] cnt, input logic busy, input logic done);
    tbl[i].start = s; tbl[i].rv = v; tbl[i].d = d; tbl[i].we = we; tbl[i].addr = addr;
    tbl[i].di = di; tbl[i].cnt = cnt; tbl[i].busy = busy; tbl[i].done = done;
  endtask

`ifdef PIXEL_LOADER_CHKSUM_EN
  task automatic drive1(input logic s, input logic v, input logic [7:0] d);
    @(negedge clk);
    bus1.start = s; bus1.rx_valid = v; bus1.rx_data = d;
    @(posedge clk); #1;
    bus1.start = 1'b0; bus1.rx_valid = 1'b0;
  endtask

  task automatic frame1(input logic [7:0] cb, input logic exp_ce, input string tag);
    drive1(1'b1, 1'b0, 8'h00);
    drive1(1'b0, 1'b1, 8'h01);
    drive1(1'b0, 1'b1, 8'h02);
    drive1(1'b0, 1'b1, 8'h04);
    chk({tag, ".we"}, 32'(bus1.mem_we), 32'd1);
    chk({tag, ".di"}, 32'(bus1.mem_di), 32'h010204);
    drive1(1'b0, 1'b0, 8'h00);
    chk({tag, ".busy_chk"}, 32'(bus1.busy), 32'd1);
    chk({tag, ".done_chk"}, 32'(bus1.done), 32'd0);
    chk({tag, ".cnt"}, 32'(bus1.pix_count), 32'd1);
    drive1(1'b0, 1'b1, cb);
    chk({tag, ".done"}, 32'(bus1.done), 32'd1);
    chk({tag, ".busy"}, 32'(bus1.busy), 32'd0);
    chk({tag, ".chk_err"}, 32'(bus1.chk_err), 32'(exp_ce));
  endtask
`endif

  logic tail_busy, tail_done;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
`ifdef PIXEL_LOADER_CHKSUM_EN
    bus1.start = 1'b0; bus1.rx_valid = 1'b0; bus1.rx_data = 8'h00;
`endif
    repeat (2) @(posedge clk);
    #1;
    expect_out("rst", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst.di", 32'(bus.mem_di), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Full 4-pixel frame, back to back, plus one stray byte past the end
`ifdef PIXEL_LOADER_CHKSUM_EN
    tail_busy = 1'b1; tail_done = 1'b0;
`else
    tail_busy = 1'b0; tail_done = 1'b1;
`endif
    set_vec(0,  1, 0, 8'h00, 0, 0, 24'h0,      0, 1, 0);
    set_vec(1,  0, 1, 8'h01, 0, 0, 24'h0,      0, 1, 0);
    set_vec(2,  0, 1, 8'h02, 0, 0, 24'h0,      0, 1, 0);
    set_vec(3,  0, 1, 8'h03, 1, 0, 24'h010203, 0, 1, 0);
    set_vec(4,  0, 1, 8'h04, 0, 1, 24'h0,      1, 1, 0);
    set_vec(5,  0, 1, 8'h05, 0, 1, 24'h0,      1, 1, 0);
    set_vec(6,  0, 1, 8'h06, 1, 1, 24'h040506, 1, 1, 0);
    set_vec(7,  0, 1, 8'h07, 0, 2, 24'h0,      2, 1, 0);
    set_vec(8,  0, 1, 8'h08, 0, 2, 24'h0,      2, 1, 0);
    set_vec(9,  0, 1, 8'h09, 1, 2, 24'h070809, 2, 1, 0);
    set_vec(10, 0, 1, 8'h0A, 0, 3, 24'h0,      3, 1, 0);
    set_vec(11, 0, 1, 8'h0B, 0, 3, 24'h0,      3, 1, 0);
    set_vec(12, 0, 1, 8'h0C, 1, 3, 24'h0A0B0C, 3, 1, 0);
    set_vec(13, 0, 1, 8'h0D, 0, 0, 24'h0,      4, tail_busy, tail_done);
    set_vec(14, 0, 0, 8'h00, 0, 0, 24'h0,      4, tail_busy, tail_done);
    set_vec(15, 0, 0, 8'h00, 0, 0, 24'h0,      4, tail_busy, tail_done);
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].start, tbl[i].rv, tbl[i].d);
      expect_out($sformatf("v%0d", i), tbl[i].we, tbl[i].addr, tbl[i].di, tbl[i].cnt,
                 tbl[i].busy, tbl[i].done, 1'b0);
    end
`ifdef PIXEL_LOADER_CHKSUM_EN
    drive(1'b0, 1'b1, 8'h0C);
    expect_out("frame_chk", 1'b0, '0, '0, 11'd4, 1'b0, 1'b1, 1'b0);
`endif

    // Bytes in DONE are ignored
    drive(1'b0, 1'b1, 8'h55);
    expect_out("done_ign0", 1'b0, '0, '0, 11'd4, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 8'h66);
    expect_out("done_ign1", 1'b0, '0, '0, 11'd4, 1'b0, 1'b1, 1'b0);

    // Abort mid-pixel; start wins over a simultaneous byte
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'hAA);
    drive(1'b0, 1'b1, 8'hBB);
    drive(1'b1, 1'b1, 8'hCC);
    expect_out("abort", 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h11);
    expect_out("restart_r", 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h22);
    expect_out("restart_g", 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h33);
    expect_out("restart_b", 1'b1, '0, 24'h112233, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00);
    expect_out("restart_post", 1'b0, 10'd1, '0, 11'd1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-pixel
    drive(1'b0, 1'b1, 8'h44);
    @(negedge clk); #2 reset = 1'b1;
    #1;
    expect_out("rst_mid", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid.di", 32'(bus.mem_di), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Bytes in IDLE are ignored; packer index starts fresh
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'h70 + 8'(i));
      expect_out($sformatf("idle_ign%0d", i), 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h9A);
    drive(1'b0, 1'b1, 8'hBC);
    expect_out("fresh_g", 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'hDE);
    expect_out("fresh_b", 1'b1, '0, 24'h9ABCDE, '0, 1'b1, 1'b0, 1'b0);

`ifdef PIXEL_LOADER_CHKSUM_EN
    frame1(8'h07, 1'b0, "chk_ok");
    frame1(8'h06, 1'b1, "chk_bad");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pixel_loader.md
Name: pixel_loader

Overview:
- Upstream stage of the image-processing datapath.
- Takes a byte stream from the board's UART receiver and packs each group of three bytes (R, G, B) into one 24-bit pixel.
- Writes the pixels sequentially into the source pixel RAM (1024 x 24 inferred RAM) that the filter sequencer later reads.
- Asserts done when the whole frame is loaded, so the sequencer can be released.

Parameters:
- ADDR_BITS, 10, pixel RAM address width.
- NUM_PIXELS, 1024, pixels per frame; must be 1..2^ADDR_BITS.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; (re)starts a frame load at address 0
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
- mem_we  output  1  source RAM write enable
- mem_addr  output  ADDR_BITS  source RAM address
- mem_di  output  24  source RAM write data {R,G,B}
- busy  output  1  high while in LOAD or CHECK
- done  output  1  high in DONE; held until the next start or reset
- pix_count  output  ADDR_BITS+1  pixels written in the current frame
- chk_err  output  1  checksum mismatch flag (see Optional Feature)

Behaviour:
- Reset:
  - Clocking: clk; reset is asynchronous and active-high.
  - On reset: state=IDLE; mem_we=0, mem_addr=0, mem_di=0, busy=0, done=0, pix_count=0, chk_err=0; internal byte index=0.
  - Reset mid-load aborts the load. RAM contents are not cleared.
- All outputs are registered.
- States:
  - IDLE: rx_valid is ignored. start -> LOAD.
  - LOAD: consumes bytes.
  - CHECK: exists only with the feature enabled.
  - DONE: rx_valid is ignored. start -> LOAD.
- Entering LOAD (start seen in any state): mem_addr=0, pix_count=0, byte index=0, done=0, chk_err=0.
- start in LOAD or CHECK aborts the current frame and restarts at address 0. Partial pixel bytes are discarded.
- start and rx_valid in the same cycle: start wins; the byte is dropped.
- Byte packing in LOAD:
  - Byte index 0: byte -> R, mem_di[23:16].
  - Byte index 1: byte -> G, mem_di[15:8].
  - Byte index 2: byte -> B, mem_di[7:0].
  - The index wraps 2 -> 0.
- Write timing:
  - Sampling the third byte at edge N drives mem_we=1 with the assembled word and the current mem_addr during cycle N+1.
  - mem_we is high for exactly one cycle.
  - At edge N+1 (the write edge): mem_addr increments and pix_count increments.
- mem_we is never asserted outside LOAD.
- Back-to-back rx_valid on consecutive cycles must be accepted with no byte lost. A minimum of 3 cycles per pixel therefore suffices.
- Frame end:
  - On the write of pixel NUM_PIXELS-1, the next state is DONE. With the feature enabled, the next state is CHECK instead.
  - mem_addr wraps to 0 at that point and pix_count=NUM_PIXELS.
  - No write is ever made past NUM_PIXELS-1.
- Status outputs: busy = (state==LOAD || state==CHECK); done = (state==DONE).
- Without the feature: chk_err is constant 0.

Optional Feature:
- Macro: PIXEL_LOADER_CHKSUM_EN.
- When defined:
  - A running 8-bit XOR of every accepted frame byte is kept; it is cleared on entering LOAD.
  - After the last pixel write, the FSM enters CHECK and waits for one further rx_valid byte.
  - chk_err is registered as (byte != running XOR).
  - The FSM then goes to DONE; chk_err holds until the next start or reset.
- When undefined:
  - No CHECK state and no XOR register.
  - LOAD goes directly to DONE; chk_err is tied to 0.

Decomposition:
- Shared package (pixel_pkg):
  - PIXEL_W=24 and CH_W=8.
  - Channel slice positions: R [23:16], G [15:8], B [7:0].
  - State encoding localparams: IDLE=2'b00, LOAD=2'b01, CHECK=2'b10, DONE=2'b11.
- One natural sub-module: rgb_packer.
  - Byte index counter plus R/G holding registers.
  - Emits a 24-bit word with a one-cycle word_valid.
- The FSM, address counter and checksum stay in pixel_loader.

Test Plan:
1. Reset-state check: assert reset mid-stream -> all outputs 0 on the same cycle as reset, state IDLE.
2. Single-pixel packing, NUM_PIXELS=4: start, then bytes 0x12, 0x34, 0x56 on consecutive cycles -> next cycle mem_we=1, mem_addr=0, mem_di=24'h123456; pix_count=1 after that edge.
3. Full-frame load, NUM_PIXELS=4, 12 back-to-back bytes 0x01..0x0C:
   - Writes 010203@0, 040506@1, 070809@2, 0A0B0C@3.
   - Then done=1, busy=0, pix_count=4, mem_addr=0.
   - A 13th byte causes no write.
4. Abort and restart: start, bytes AA, BB, then start together with rx_valid carrying byte CC -> CC dropped; bytes 11, 22, 33 then write 112233@0.
5. Ignored bytes: rx_valid pulses in IDLE and in DONE -> mem_we stays 0, mem_addr and pix_count unchanged.
6. Checksum, PIXEL_LOADER_CHKSUM_EN, NUM_PIXELS=1, bytes 01 02 04:
   - Check byte 07 -> done=1, chk_err=0.
   - Repeat with check byte 06 -> done=1, chk_err=1.
